alu_exec: RTL

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/aardvark_pkg.sv | 32 +++
 rtl/alu_comb.sv | 40 ++++
 rtl/alu_exec.sv | 125 ++++++++++++
 3 files changed

// File: rtl/aardvark_pkg.sv
// Shared definitions for the aardvark datapath: ALU operation codes (also
// produced by the ALU control unit), sequencer state encoding, default widths.
package aardvark_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int ALU_SHW   = 3;

    typedef enum logic [2:0] {
        ALU_ILL0 = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_NAND = 3'b010,
        ALU_SLT  = 3'b011,
        ALU_SL   = 3'b100,
        ALU_SR   = 3'b101,
        ALU_BEQ  = 3'b110,
        ALU_ILL7 = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } alu_state_e;

    // Shift operations run through the multi-cycle shifter, everything else
    // completes through the single-cycle combinational ALU.
    function automatic logic is_shift_op(input logic [2:0] code);
        return (code == ALU_SL) || (code == ALU_SR);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle combinational ALU: add, nand, slt, beq-compare and the
// illegal-code response. Shift codes are handled by the sequencer instead.
module alu_comb
    import aardvark_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             zero,
    output logic             illegal
);

    logic [WIDTH:0] sum;

    // Operation select; zero is derived from the selected result so that
    // beq reports equality and illegal codes report zero=1.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        res     = '0;
        carry   = 1'b0;
        illegal = 1'b0;
        case (op)
            ALU_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            ALU_NAND: res = ~(a & b);
            ALU_SLT:  res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            ALU_BEQ:  res = a - b;
            ALU_SL, ALU_SR: res = '0;
            default:  illegal = 1'b1;
        endcase
        zero = (res == '0);
    end

endmodule

// File: rtl/alu_exec.sv
// Sequenced ALU execution unit. Handshake: start is sampled only while idle
// (busy=0); an accepted request raises busy the next cycle, and completion is
// signalled by a one-cycle done pulse with result/flags valid, after which busy
// drops. Requests presented while busy (including the done cycle) are dropped.
module alu_exec
    import aardvark_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = ALU_SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ALUctrlbits,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             illegal
);

    alu_state_e       state_q, state_d;
    alu_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;       // operand A, doubles as shift working register
    logic [WIDTH-1:0] b_q, b_d;
    logic [SHW-1:0]   cnt_q, cnt_d;   // remaining shift steps
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] comb_res;
    logic             comb_carry, comb_zero, comb_illegal;

    alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .res     (comb_res),
        .carry   (comb_carry),
        .zero    (comb_zero),
        .illegal (comb_illegal)
    );

    // Sequencer: latch request in IDLE, compute/shift, publish result in DONE.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = alu_op_e'(ALUctrlbits);
                    a_d     = op_a;
                    b_d     = op_b;
                    cnt_d   = op_b[SHW-1:0];
                    state_d = is_shift_op(ALUctrlbits) ? ST_SHIFT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d  = comb_res;
                zero_d    = comb_zero;
                carry_d   = comb_carry;
                illegal_d = comb_illegal;
                state_d   = ST_DONE;
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    result_d  = a_q;
                    zero_d    = (a_q == '0);
                    carry_d   = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    a_d   = (op_q == ALU_SL) ? (a_q << 1) : (a_q >> 1);
                    cnt_d = cnt_q - SHW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= ALU_ILL0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign result  = result_q;
    assign zero    = zero_q;
    assign carry   = carry_q;
    assign illegal = illegal_q;

endmodule
